// File: rtl/ntt_stage_sched.sv
// ntt_stage_sched: address/strobe scheduler for an in-place radix-2 NTT.
// Issues N/2 butterfly reads per stage. After each stage it waits BF_LAT
// cycles so the stage's write-backs drain before the next stage reads.
// Write strobes and addresses are the read strobes and addresses delayed by BF_LAT.
module ntt_stage_sched #(
  parameter int LOGN   = 8,
  parameter int BF_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOGN)-1:0]  stage,
  output logic                     rd_en,
  output logic [LOGN-1:0]          rd_addr_a,
  output logic [LOGN-1:0]          rd_addr_b,
  output logic [LOGN-1:0]          tw_addr,
  output logic                     wr_en,
  output logic [LOGN-1:0]          wr_addr_a,
  output logic [LOGN-1:0]          wr_addr_b
);

  localparam int SW = $clog2(LOGN);
  localparam int JW = LOGN - 1;
  localparam int CW = $clog2(BF_LAT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]      state;
  logic [JW-1:0]   j;
  logic [CW-1:0]   cnt;

  logic [SW-1:0]   ld_stage;
  logic [JW-1:0]   ld_j;
  logic [SW-1:0]   p;
  logic [LOGN-1:0] jx;
  logic [LOGN-1:0] lo_mask;
  logic [LOGN-1:0] nxt_a;
  logic [LOGN-1:0] nxt_b;
  logic [LOGN-1:0] nxt_tw;

  logic [BF_LAT-1:0] en_pipe;
  logic [LOGN-1:0]   a_pipe [BF_LAT];
  logic [LOGN-1:0]   b_pipe [BF_LAT];

  // Addresses for the pair that will be issued in the next cycle. They are
  // computed ahead so that rd_addr_*, tw_addr and rd_en come straight from flops.
  always_comb begin
    ld_stage = '0;
    ld_j     = '0;
    case (state)
      S_ISSUE: begin
        ld_stage = stage;
        ld_j     = j + JW'(1);
      end
      S_WAIT: begin
        ld_stage = stage + SW'(1);
        ld_j     = '0;
      end
      default: begin
        ld_stage = '0;
        ld_j     = '0;
      end
    endcase
    p       = SW'(LOGN - 1) - ld_stage;
    jx      = {1'b0, ld_j};
    lo_mask = ~({LOGN{1'b1}} << p);
    // Open a gap at bit p. Bits of j at or above p move up one place.
    nxt_a   = ((jx & ~lo_mask) << 1) | (jx & lo_mask);
    nxt_b   = nxt_a | (LOGN'(1) << p);
    nxt_tw  = (LOGN'(1) << ld_stage) + (jx >> p);
  end

  // Control FSM: stage/pair sequencing, drain wait and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stage     <= '0;
      j         <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_ISSUE;
            stage     <= '0;
            j         <= '0;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr_a <= nxt_a;
            rd_addr_b <= nxt_b;
            tw_addr   <= nxt_tw;
          end
        end
        S_ISSUE: begin
          if (&j) begin
            state <= S_WAIT;
            cnt   <= CW'(BF_LAT - 1);
            rd_en <= 1'b0;
          end else begin
            j         <= j + JW'(1);
            rd_addr_a <= nxt_a;
            rd_addr_b <= nxt_b;
            tw_addr   <= nxt_tw;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            if (stage == SW'(LOGN - 1)) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_ISSUE;
              stage     <= stage + SW'(1);
              j         <= '0;
              rd_en     <= 1'b1;
              rd_addr_a <= nxt_a;
              rd_addr_b <= nxt_b;
              tw_addr   <= nxt_tw;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Write strobe delay line. It is cleared by reset so that reads in flight
  // when reset arrives never produce a write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_pipe <= '0;
    end else begin
      en_pipe[0] <= rd_en;
      for (int unsigned i = 1; i < BF_LAT; i++) begin
        en_pipe[i] <= en_pipe[i-1];
      end
    end
  end

  // Write address delay line. It has no reset because addresses are only used while wr_en is set.
  always_ff @(posedge clk) begin
    a_pipe[0] <= rd_addr_a;
    b_pipe[0] <= rd_addr_b;
    for (int unsigned i = 1; i < BF_LAT; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end

  assign wr_en     = en_pipe[BF_LAT-1];
  assign wr_addr_a = a_pipe[BF_LAT-1];
  assign wr_addr_b = b_pipe[BF_LAT-1];

endmodule
